// File: rtl/convcor_peak.sv
// convcor_peak: peak tracker for one result burst of the convolution/correlation
// core. While in_valid is high, each signed 36-bit sample is compared against the
// running peak. When the burst ends, a one-cycle summary is emitted: peak value,
// its index, the burst length and an overflow flag.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_data   burst sample stream (no backpressure)
//   out_valid           one-cycle summary strobe
//   out_peak            original signed peak sample
//   out_idx             zero-based index of the peak (earliest on ties)
//   out_len             samples accepted, 1..2**IDX_W
//   out_ovf             burst ran past 2**IDX_W samples
//
// Build option: CONVCOR_PEAK_ABS_EN selects magnitude ordering (|x|) instead of
// signed ordering for the peak search. out_peak is always the signed sample.
module convcor_peak #(
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [35:0]       in_data,
  output logic              out_valid,
  output logic [35:0]       out_peak,
  output logic [IDX_W-1:0]  out_idx,
  output logic [IDX_W:0]    out_len,
  output logic              out_ovf
);

  localparam logic [IDX_W:0] MAXLEN = {1'b1, {IDX_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q, state_d;
  logic [35:0]      acc_peak_q, acc_peak_d;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic [IDX_W:0]   acc_len_q, acc_len_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [35:0]      sum_peak_q, sum_peak_d;
  logic [IDX_W-1:0] sum_idx_q, sum_idx_d;
  logic [IDX_W:0]   sum_len_q, sum_len_d;
  logic             sum_ovf_q, sum_ovf_d;

  // Map a sample to an unsigned key so one unsigned compare covers both modes.
  // Signed mode flips the sign bit (offset binary). Magnitude mode negates
  // negatives; -2^35 becomes 2^35, which fits in 36 unsigned bits.
  function automatic logic [35:0] key_of(input logic [35:0] x);
`ifdef CONVCOR_PEAK_ABS_EN
    return x[35] ? (~x + 36'd1) : x;
`else
    return {~x[35], x[34:0]};
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    acc_peak_d = acc_peak_q;
    acc_idx_d  = acc_idx_q;
    acc_len_d  = acc_len_q;
    acc_ovf_d  = acc_ovf_q;
    sum_peak_d = sum_peak_q;
    sum_idx_d  = sum_idx_q;
    sum_len_d  = sum_len_q;
    sum_ovf_d  = sum_ovf_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          if (acc_len_q == MAXLEN) begin
            acc_ovf_d = 1'b1;
          end else begin
            // strictly greater keeps the earliest index on ties
            if (key_of(in_data) > key_of(acc_peak_q)) begin
              acc_peak_d = in_data;
              acc_idx_d  = acc_len_q[IDX_W-1:0];
            end
            acc_len_d = acc_len_q + (IDX_W+1)'(1);
          end
        end else begin
          sum_peak_d = acc_peak_q;
          sum_idx_d  = acc_idx_q;
          sum_len_d  = acc_len_q;
          sum_ovf_d  = acc_ovf_q;
          state_d    = DONE;
        end
      end
      default: begin
        // IDLE and DONE: a sample here starts a new burst; the summary
        // registers stay untouched so DONE still reports the old burst.
        if (in_valid) begin
          acc_peak_d = in_data;
          acc_idx_d  = '0;
          acc_len_d  = (IDX_W+1)'(1);
          acc_ovf_d  = 1'b0;
          state_d    = ACC;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_peak_q <= '0;
      acc_idx_q  <= '0;
      acc_len_q  <= '0;
      acc_ovf_q  <= 1'b0;
      sum_peak_q <= '0;
      sum_idx_q  <= '0;
      sum_len_q  <= '0;
      sum_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_peak_q <= acc_peak_d;
      acc_idx_q  <= acc_idx_d;
      acc_len_q  <= acc_len_d;
      acc_ovf_q  <= acc_ovf_d;
      sum_peak_q <= sum_peak_d;
      sum_idx_q  <= sum_idx_d;
      sum_len_q  <= sum_len_d;
      sum_ovf_q  <= sum_ovf_d;
    end
  end

  // Reset held during DONE suppresses the summary.
  assign out_valid = (state_q == DONE) && rst_n;
  assign out_peak  = out_valid ? sum_peak_q : '0;
  assign out_idx   = out_valid ? sum_idx_q  : '0;
  assign out_len   = out_valid ? sum_len_q  : '0;
  assign out_ovf   = out_valid ? sum_ovf_q  : 1'b0;

endmodule

// File: tb/tb_convcor_peak.sv
// Bench for convcor_peak: directed scenarios plus random bursts checked against
// a plain-arithmetic peak model. Define CONVCOR_PEAK_ABS_EN for both bench and
// design to exercise magnitude ordering.
module tb_convcor_peak;

  localparam int IDX_W  = 5;
  localparam int MAXLEN = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [35:0]       in_data;
  logic              out_valid;
  logic [35:0]       out_peak;
  logic [IDX_W-1:0]  out_idx;
  logic [IDX_W:0]    out_len;
  logic              out_ovf;

  int vecs = 0;
  int errs = 0;
  logic [35:0] stim[$];

  convcor_peak #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_peak(out_peak), .out_idx(out_idx),
    .out_len(out_len), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // {valid, peak, idx, len, ovf}
  function automatic logic [48:0] obs();
    return {out_valid, out_peak, out_idx, out_len, out_ovf};
  endfunction

  function automatic logic [48:0] summ(logic v, logic [35:0] p, int i, int l, logic o);
    return {v, p, 5'(i), 6'(l), o};
  endfunction

  function automatic longint key(logic [35:0] x);
    longint v = longint'($signed(x));
`ifdef CONVCOR_PEAK_ABS_EN
    if (v < 0) v = -v;
`endif
    return v;
  endfunction

  // Expected summary of the burst in stim: first MAXLEN samples count, the
  // earliest sample with the largest key wins.
  function automatic logic [48:0] model();
    int n = stim.size();
    int len = (n > MAXLEN) ? MAXLEN : n;
    int best = 0;
    for (int i = 1; i < len; i++)
      if (key(stim[i]) > key(stim[best])) best = i;
    return summ(1'b1, stim[best], best, len, n > MAXLEN);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives stim one sample per cycle, then drops in_valid (cycle N+1).
  task automatic drive_burst();
    foreach (stim[i]) begin
      in_valid = 1'b1; in_data = stim[i];
      tick();
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    vecs++;
    if (obs() !== '0) begin errs++; $display("FAIL reset: got %h want 0", obs()); end
    rst_n = 1'b1;
    tick();
    vecs++;
    if (obs() !== '0) begin errs++; $display("FAIL reset_idle: got %h want 0", obs()); end
  endtask

  task automatic test_basic();
    stim = '{36'sd5, -36'sd3, 36'sd12, 36'sd7};
    drive_burst();
    vecs++;
    if (obs() !== '0) begin errs++; $display("FAIL basic_early: got %h want 0", obs()); end
    tick();
    vecs++;
    if (obs() !== summ(1, 36'sd12, 2, 4, 0)) begin
      errs++; $display("FAIL basic: got %h want %h", obs(), summ(1, 36'sd12, 2, 4, 0));
    end
    tick();
    vecs++;
    if (obs() !== '0) begin errs++; $display("FAIL basic_pulse: got %h want 0", obs()); end
  endtask

  task automatic test_key_mode();
    logic [48:0] exp;
`ifdef CONVCOR_PEAK_ABS_EN
    exp = summ(1, -36'sd20, 1, 3, 0);
`else
    exp = summ(1, 36'sd9, 2, 3, 0);
`endif
    stim = '{36'sd4, -36'sd20, 36'sd9};
    drive_burst();
    tick();
    vecs++;
    if (obs() !== exp) begin errs++; $display("FAIL key_mode: got %h want %h", obs(), exp); end
    tick();
  endtask

  task automatic test_ties();
    stim = '{36'sd8, 36'sd8, 36'sd3};
    drive_burst();
    tick();
    vecs++;
    if (obs() !== summ(1, 36'sd8, 0, 3, 0)) begin
      errs++; $display("FAIL ties: got %h want %h", obs(), summ(1, 36'sd8, 0, 3, 0));
    end
    tick();
  endtask

  task automatic test_overflow();
    stim.delete();
    for (int i = 0; i < 40; i++) stim.push_back(36'(i));
    drive_burst();
    tick();
    vecs++;
    if (obs() !== summ(1, 36'sd31, 31, 32, 1)) begin
      errs++; $display("FAIL overflow: got %h want %h", obs(), summ(1, 36'sd31, 31, 32, 1));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    stim = '{36'sd1, 36'sd2};
    drive_burst();
    tick();
    in_valid = 1'b1; in_data = -36'sd1;   // new burst starts in DONE
    vecs++;
    if (obs() !== summ(1, 36'sd2, 1, 2, 0)) begin
      errs++; $display("FAIL b2b_first: got %h want %h", obs(), summ(1, 36'sd2, 1, 2, 0));
    end
    tick();
    in_valid = 1'b0; in_data = '0;
    vecs++;
    if (obs() !== '0) begin errs++; $display("FAIL b2b_gap: got %h want 0", obs()); end
    tick();
    vecs++;
    if (obs() !== summ(1, -36'sd1, 0, 1, 0)) begin
      errs++; $display("FAIL b2b_second: got %h want %h", obs(), summ(1, -36'sd1, 0, 1, 0));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    stim = '{36'sd100, 36'sd200, 36'sd300};
    foreach (stim[i]) begin
      in_valid = 1'b1; in_data = stim[i];
      tick();
    end
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int c = 0; c < 3; c++) begin
      vecs++;
      if (obs() !== '0) begin errs++; $display("FAIL reset_mid_hold: got %h want 0", obs()); end
      tick();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      vecs++;
      if (obs() !== '0) begin errs++; $display("FAIL reset_mid_stale: got %h want 0", obs()); end
      tick();
    end
    stim = '{36'sd6};
    drive_burst();
    tick();
    vecs++;
    if (obs() !== summ(1, 36'sd6, 0, 1, 0)) begin
      errs++; $display("FAIL reset_mid_next: got %h want %h", obs(), summ(1, 36'sd6, 0, 1, 0));
    end
    tick();
  endtask

  task automatic test_random();
    logic [48:0] exp;
    logic [35:0] v;
    int gap;
    for (int b = 0; b < 30; b++) begin
      stim.delete();
      for (int i = 0, n = $urandom_range(1, 40); i < n; i++) begin
        case ($urandom_range(0, 3))
          0: v = 36'($signed(5'($urandom_range(0, 31))));   // small, tie-prone
          1: v = {4'($urandom), 32'($urandom)};
          2: v = 36'h8_0000_0000;                           // -2^35
          default: v = 36'h7_FFFF_FFFF;
        endcase
        stim.push_back(v);
      end
      exp = model();
      drive_burst();
      vecs++;
      if (obs() !== '0) begin errs++; $display("FAIL rand_early %0d: got %h want 0", b, obs()); end
      tick();
      vecs++;
      if (obs() !== exp) begin errs++; $display("FAIL rand %0d: got %h want %h", b, obs(), exp); end
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_key_mode();
    test_ties();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/convcor_peak.md
# convcor_peak

Downstream stage of the convolution/correlation core. Consumes one result burst (`in_valid` high with a signed 36-bit sample per cycle), tracks the peak sample, its index and the burst length, and emits a single-cycle summary once the burst ends. It feeds the lag/peak reporting logic and the pattern checker that follow the core.

## Interface
- `IDX_W`, default 5: index width. Maximum counted burst length is `MAXLEN` = 2**`IDX_W` = 32 samples.
- `clk` input 1: single clock; everything updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: high while a burst sample is present; a burst is a maximal run of high cycles.
- `in_data` input 36: two's-complement sample from the core's `out`.
- `out_valid` output 1: one-cycle pulse when a summary is valid.
- `out_peak` output 36: the original signed value of the peak sample.
- `out_idx` output `IDX_W`: zero-based position of the peak inside the burst.
- `out_len` output `IDX_W`+1: number of samples accepted, from 1 to `MAXLEN`.
- `out_ovf` output 1: the burst exceeded `MAXLEN` samples.

## Operation
- FSM states:
  - IDLE (reset state):
    - `in_valid`=1: load the sample as the current peak with idx=0, len=1, ovf=0. Go to ACC.
  - ACC:
    - `in_valid`=1 and len<`MAXLEN`: compare the sample's key against the stored peak key. Update the peak and idx only on strictly greater, so ties keep the earliest index. len+=1.
    - `in_valid`=1 and len=`MAXLEN`: the sample is ignored and ovf is set to 1.
    - `in_valid`=0: latch the summary registers and go to DONE.
  - DONE: `out_valid`=1 for exactly this cycle.
    - `in_valid`=1: treat as the IDLE load (new burst, go to ACC).
    - Otherwise go to IDLE.
- The comparison key is defined under Configuration.
- Accumulation registers are separate from the summary registers. The summary holds its values during DONE while a new burst loads.
- Outputs `out_peak`, `out_idx`, `out_len` and `out_ovf` are 0 whenever `out_valid`=0.
- Reset mid-burst or during DONE: return to IDLE and discard the partial burst; no summary is emitted.
- A one-sample burst yields peak=that sample, idx=0, len=1.

## Timing
- Reset values: `out_valid`=0, `out_peak`=0, `out_idx`=0, `out_len`=0, `out_ovf`=0, state=IDLE.
- Last sample at cycle N and `in_valid`=0 at cycle N+1: `out_valid`=1 during cycle N+2 only.
- Minimum gap between bursts is 1 low cycle. A new burst may begin in the DONE cycle with no sample lost.
- No backpressure. The block accepts every cycle unconditionally.

## Configuration
- `CONVCOR_PEAK_ABS_EN`:
  - Defined: the key is the unsigned 36-bit magnitude |`in_data`|. -2^35 maps to 2^35, which is representable with no saturation. Peaks may be negative samples.
  - Undefined: the key is the signed value, so the peak is the maximum signed sample.
  - In both cases `out_peak` reports the original signed sample.

## Test plan
- Reset, then burst 5, -3, 12, 7 followed by one low cycle -> `out_valid` pulses 2 cycles after the last sample. Summary: peak=12, idx=2, len=4, ovf=0.
- Burst 4, -20, 9:
  - With `CONVCOR_PEAK_ABS_EN` -> peak=-20, idx=1.
  - Without it -> peak=9, idx=2.
  - Both: len=3.
- Ties: burst 8, 8, 3 -> idx=0, peak=8.
- Overflow: 40 samples equal to their index 0..39 -> peak=31, idx=31, len=32, ovf=1.
- Back-to-back: burst {1, 2}, one low cycle, then a burst {-1} starting in the DONE cycle.
  - First summary: peak=2, idx=1, len=2.
  - Next summary: peak=-1, len=1, with no lost sample.
- Reset asserted mid-burst after 3 samples, then burst {6} -> no summary for the aborted burst. Next summary: peak=6, len=1, and all outputs were 0 during reset.
